alu_pipe: RTL
=============

# alu_pipe

Parametrised, pipelined successor to the datapath's 8-bit adder ALU. It adds a 16-opcode operation set, status flags (Z/N/C/V) and a two-stage registered pipeline with valid/ready handshakes on input and output. It sits between the register-file read ports and the write-back stage, and tolerates write-back stalls without losing operations.

## Interface
- WIDTH, 8: operand and result width in bits, minimum 4.
- SHW, $clog2(WIDTH): number of shift-amount bits taken from Data2.

- Clk  in  1  rising-edge clock.
- Clear_n  in  1  asynchronous reset, active-low.
- In_Valid  in  1  operation presented on ALUOp/Data1/Data2.
- In_Ready  out  1  pipeline accepts the operation this cycle.
- ALUOp  in  4  operation code.
- Data1, Data2  in  WIDTH  operands.
- Out_Valid  out  1  ALU_Result/Flags hold a completed operation.
- Out_Ready  in  1  consumer takes the result this cycle.
- ALU_Result  out  WIDTH  registered result.
- Flags  out  4  registered {V,C,N,Z}.

## Operation
- Opcodes:
  - 0 NOP: result 0.
  - 1 ADD: Data1+Data2.
  - 2 SUB: Data1-Data2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: Data1<<Data2[SHW-1:0].
  - 7 SHR: logical right shift, same amount.
  - 8 SLT: 1 if Data1<Data2 signed, else 0.
  - 9 PASSA: result = Data1.
  - 10–15 reserved: result 0, all flags 0.
- Z: result == 0. This holds for every defined opcode, including NOP.
- N: result MSB.
- C:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: borrow, i.e. Data1 < Data2 unsigned.
  - All other opcodes: 0.
- V: two's-complement overflow for ADD/SUB; 0 otherwise.
- Arithmetic is performed at WIDTH+1 bits. The result is truncated to WIDTH bits unless saturation is compiled in (see Configuration).
- Stage 1 registers ALUOp/Data1/Data2 plus a valid bit.
- Stage 2 registers ALU_Result/Flags plus Out_Valid. The computation happens between stage 1 and stage 2.
- Handshake:
  - An input transfer occurs when In_Valid && In_Ready.
  - An output transfer occurs when Out_Valid && Out_Ready.
  - Stage 2 advances when !Out_Valid || Out_Ready.
  - Stage 1 advances when !s1_valid || stage 2 advances.
  - In_Ready equals the stage-1 advance condition. It is combinational from Out_Ready; no combinational path runs from In_Valid.
- Results leave strictly in acceptance order. Nothing is dropped or duplicated.
- While Out_Valid=1 && Out_Ready=0, ALU_Result and Flags hold stable.

## Timing
- Reset (Clear_n low, asynchronous): stage-1 valid=0, Out_Valid=0, ALU_Result=0, Flags=0.
  - In_Ready reads 1 during reset.
  - Reset deasserts synchronously to Clk.
- Reset mid-operation discards every in-flight operation. No result is emitted for them.
- Latency: an operation accepted at edge n appears with Out_Valid=1 after edge n+2, given no stall.
- Throughput: one operation per cycle while Out_Ready=1.
- Full stall (both stages valid, Out_Ready=0): In_Ready=0.
- Simultaneous output transfer and input transfer in the same cycle is legal and keeps full throughput.
- Stage-1 data registers load only on an input transfer. Stage-2 registers load only when stage 2 advances and s1_valid=1.

## Configuration
- ALU_PIPE_SAT_EN defined: ADD/SUB saturate signed.
  - Positive overflow gives 0111…1; negative overflow gives 1000…0.
  - V is still reported as 1.
  - Z/N are computed on the saturated result.
- ALU_PIPE_SAT_EN undefined: ADD/SUB wrap modulo 2^WIDTH.
- All other opcodes are unaffected either way.

## Structure
- Package alu_pipe_pkg holds:
  - the opcode enum (ALU_NOP…ALU_PASSA);
  - flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3).
- Sub-module alu_pipe_core: purely combinational, parametrised by WIDTH. It computes result and flags from op/a/b and contains the saturation logic.
- The top level owns both pipeline stages and the handshake.

## Test plan
- WIDTH=8, ADD 200+100 → 44 (0x2C), C=1, V=0, N=0, Z=0, appearing 2 cycles after acceptance.
- ADD 100+100:
  - without macro → 0xC8, V=1, N=1;
  - with ALU_PIPE_SAT_EN → 0x7F, V=1, N=0.
- SUB 5-7 → 0xFE, C=1, N=1, V=0. SLT 0x80,0x01 → 1. SHL 0x01 by 9 → 0x02 (amount taken mod 8). Opcode 12 → 0, Flags=0.
- Backpressure:
  - Stimulus: 5 back-to-back ops with Out_Ready=0 for 4 cycles, then Out_Ready=1.
  - Required: In_Ready falls after 2 accepts, outputs are held stable while stalled, and all 5 results arrive in order.
- Streaming: 16 consecutive ops with Out_Ready=1 → 16 results on 16 consecutive cycles starting at acceptance+2.
- Reset: assert Clear_n low with both stages valid → Out_Valid, ALU_Result and Flags go 0 immediately (asynchronously). After release, no stale result appears and a fresh op returns after 2 cycles.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_PASSA = 4'd9
  } alu_op_e;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_C    = 2;
  localparam int unsigned FLAG_V    = 3;

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between register-file read and write-back.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             In_Valid;
    logic             In_Ready;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] Data1;
    logic [WIDTH-1:0] Data2;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] ALU_Result;
    logic [3:0]       Flags;

    modport master (
        output In_Valid, ALUOp, Data1, Data2, Out_Ready,
        input  In_Ready, Out_Valid, ALU_Result, Flags
    );

    modport slave (
        input  In_Valid, ALUOp, Data1, Data2, Out_Ready,
        output In_Ready, Out_Valid, ALU_Result, Flags
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU: result and {V,C,N,Z} from op/a/b.
// Define ALU_PIPE_SAT_EN for signed saturation of ADD/SUB.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             defined_op;
    logic [WIDTH-1:0] res;
    flags_t           flg;

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        diff    = {1'b0, a_i} - {1'b0, b_i};
        // Overflow direction always follows a's sign, which also picks the saturation rail.
        add_ovf = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
        sub_ovf = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
    end

    always_comb begin
        res        = '0;
        flg        = '0;
        defined_op = 1'b1;
        case (op_i)
            ALU_NOP: res = '0;
            ALU_ADD: begin
                res         = sum[WIDTH-1:0];
                flg[FLAG_C] = sum[WIDTH];
                flg[FLAG_V] = add_ovf;
`ifdef ALU_PIPE_SAT_EN
                if (add_ovf) res = a_i[MSB] ? SAT_NEG : SAT_POS;
`endif
            end
            ALU_SUB: begin
                res         = diff[WIDTH-1:0];
                flg[FLAG_C] = diff[WIDTH];
                flg[FLAG_V] = sub_ovf;
`ifdef ALU_PIPE_SAT_EN
                if (sub_ovf) res = a_i[MSB] ? SAT_NEG : SAT_POS;
`endif
            end
            ALU_AND:   res = a_i & b_i;
            ALU_OR:    res = a_i | b_i;
            ALU_XOR:   res = a_i ^ b_i;
            ALU_SHL:   res = a_i << b_i[SHW-1:0];
            ALU_SHR:   res = a_i >> b_i[SHW-1:0];
            ALU_SLT:   res[0] = ($signed(a_i) < $signed(b_i));
            ALU_PASSA: res = a_i;
            default:   defined_op = 1'b0;
        endcase
        // Reserved opcodes report no flags at all, not even Z on their zero result.
        if (defined_op) begin
            flg[FLAG_Z] = (res == '0);
            flg[FLAG_N] = res[MSB];
        end
    end

    assign result_o = res;
    assign flags_o  = flg;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register, then result/flag register.
// Saturating ADD/SUB selected at build time with ALU_PIPE_SAT_EN.
module alu_pipe
  import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic       Clk,
    input logic       Clear_n,
    alu_pipe_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q,   s2_res_d;
    flags_t           s2_flg_q,   s2_flg_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flg;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (core_res),
        .flags_o  (core_flg)
    );

    // Ready depends only on pipeline state and Out_Ready, never on In_Valid.
    always_comb begin
        s2_adv = !s2_valid_q || bus.Out_Ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flg_d   = s2_flg_q;

        if (s1_adv) begin
            s1_valid_d = bus.In_Valid;
            if (bus.In_Valid) begin
                s1_op_d = bus.ALUOp;
                s1_a_d  = bus.Data1;
                s1_b_d  = bus.Data2;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = core_res;
                s2_flg_d = core_flg;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flg_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flg_q   <= s2_flg_d;
        end
    end

    assign bus.In_Ready   = s1_adv;
    assign bus.Out_Valid  = s2_valid_q;
    assign bus.ALU_Result = s2_res_q;
    assign bus.Flags      = s2_flg_q;

endmodule
